// File: rtl/configs_loader.sv
// Write-side controller for the configuration latch array: takes 32-bit words over
// valid/ready, drives each onto the latch bus with setup/strobe/hold, then checks an XOR trailer.
module configs_loader #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned WORDS         = 24,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_start,
  input  logic             io_cfg_valid,
  input  logic [WIDTH-1:0] io_cfg_data,
  output logic             io_cfg_ready,
  output logic [WIDTH-1:0] io_d_in,
  output logic [WORDS-1:0] io_configs_en,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_error
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] STRB_LAST = CNT_W'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_CHECK
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_strb_cnt;
  logic [WIDTH-1:0]   r_xor;
  logic [WIDTH-1:0]   r_d_in;
  logic [WORDS-1:0]   r_en;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic               w_accept;
  logic [WORDS-1:0]   w_en_onehot;

  assign w_accept    = r_ready & io_cfg_valid;
  assign w_en_onehot = WORDS'(1) << r_idx;

  // Single-process FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_strb_cnt <= '0;
      r_xor      <= '0;
      r_d_in     <= '0;
      r_en       <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_start) begin
            r_state <= ST_WAIT_WORD;
            r_idx   <= '0;
            r_xor   <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b1;
          end
        end

        ST_WAIT_WORD: begin
          if (w_accept) begin
            r_d_in  <= io_cfg_data;
            r_xor   <= r_xor ^ io_cfg_data;
            r_ready <= 1'b0;
            r_state <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_en       <= w_en_onehot;
          r_strb_cnt <= '0;
          r_state    <= ST_STROBE;
        end

        ST_STROBE: begin
          if (r_strb_cnt == STRB_LAST) begin
            r_en    <= '0;
            r_state <= ST_HOLD;
          end else begin
            r_strb_cnt <= r_strb_cnt + CNT_W'(1);
          end
        end

        // Ready is raised here so it is visible in the first WAIT_WORD/CHECK cycle.
        ST_HOLD: begin
          r_ready <= 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_CHECK;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= ST_WAIT_WORD;
          end
        end

        // Trailer only compared, never driven onto the latch bus.
        ST_CHECK: begin
          if (w_accept) begin
            r_done  <= 1'b1;
            r_error <= (io_cfg_data != r_xor);
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_en    <= '0;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_cfg_ready  = r_ready;
  assign io_d_in       = r_d_in;
  assign io_configs_en = r_en;
  assign io_busy       = r_busy;
  assign io_done       = r_done;
  assign io_error      = r_error;

endmodule

// File: tb/tb_configs_loader.sv
// Randomised self-checking bench for configs_loader (STROBE_CYCLES 1 and 3 instances)
// against a cycle-timeline reference model built from handshake timestamps.
module tb_configs_loader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned WORDS = 24;

  logic             clk;
  logic             rst_n;
  logic             sel;
  logic             start;
  logic             valid;
  logic [WIDTH-1:0] data;

  logic             rdy1, busy1, done1, err1;
  logic             rdy3, busy3, done3, err3;
  logic [WIDTH-1:0] d1, d3;
  logic [WORDS-1:0] en1, en3;

  logic             rst1, rst3;
  logic             rdy, busy, done, err;
  logic [WIDTH-1:0] d_in;
  logic [WORDS-1:0] en;

  // Only the selected instance leaves reset; the other is parked.
  assign rst1 = sel ? 1'b0 : rst_n;
  assign rst3 = sel ? rst_n : 1'b0;
  assign rdy  = sel ? rdy3  : rdy1;
  assign busy = sel ? busy3 : busy1;
  assign done = sel ? done3 : done1;
  assign err  = sel ? err3  : err1;
  assign d_in = sel ? d3    : d1;
  assign en   = sel ? en3   : en1;

  configs_loader #(.WIDTH(WIDTH), .WORDS(WORDS), .STROBE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst1), .io_start(start), .io_cfg_valid(valid), .io_cfg_data(data),
    .io_cfg_ready(rdy1), .io_d_in(d1), .io_configs_en(en1), .io_busy(busy1),
    .io_done(done1), .io_error(err1)
  );

  configs_loader #(.WIDTH(WIDTH), .WORDS(WORDS), .STROBE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst3), .io_start(start), .io_cfg_valid(valid), .io_cfg_data(data),
    .io_cfg_ready(rdy3), .io_d_in(d3), .io_configs_en(en3), .io_busy(busy3),
    .io_done(done3), .io_error(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_strobe = 0;
  bit mon_on   = 1'b0;

  // Reference model: remembers when each word was accepted and derives the outputs from that.
  int               cyc    = 0;
  int               m_tacc = -1000;
  int               m_k    = 0;
  int               m_kdisp = 0;
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  bit               m_err  = 1'b0;
  logic [WIDTH-1:0] m_word = '0;
  logic [WIDTH-1:0] m_xor  = '0;

  function automatic int sc();
    return sel ? 3 : 1;
  endfunction

  function automatic int rel();
    return cyc + 1 - m_tacc;
  endfunction

  function automatic bit m_ready();
    return m_busy && (rel() >= 3 + sc());
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_k <= 0; m_kdisp <= 0; m_xor <= '0; m_word <= '0; m_tacc <= -1000;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_done <= 1'b0; m_err <= 1'b0;
        m_k <= 0; m_xor <= '0; m_tacc <= -1000;
      end
    end else if (valid && m_ready()) begin
      if (m_k < WORDS) begin
        m_word  <= data;
        m_xor   <= m_xor ^ data;
        m_kdisp <= m_k;
        m_k     <= m_k + 1;
        m_tacc  <= cyc + 1;
      end else begin
        m_done <= 1'b1;
        m_err  <= (data != m_xor);
        m_busy <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [WORDS-1:0] exp_en;
    int r;
    r = rel();
    exp_en = '0;
    if (r >= 2 && r <= 1 + sc()) exp_en[m_kdisp] = 1'b1;
    if (en != '0) n_strobe++;
    if (mon_on) begin
      check("en",    64'(en),   64'(exp_en));
      check("d_in",  64'(d_in), 64'(m_word));
      check("ready", 64'(rdy),  64'(m_ready()));
      check("busy",  64'(busy), 64'(m_busy));
      check("done",  64'(done), 64'(m_done));
      check("error", 64'(err),  64'(m_err));
    end
  endtask

  // All time advances through here: check at negedge, hand back control 1ns after posedge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] words [WORDS];

  task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
    bit acc;
    valid = 1'b0;
    repeat (gap) begin
      data = $urandom;
      tick();
    end
    valid = 1'b1;
    data  = w;
    acc   = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      acc = rdy;
      tick();
    end
    valid = 1'b0;
    if (!acc) check("handshake_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_load(input bit bad, input int max_gap, input int start_at);
    logic [WIDTH-1:0] x;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_strobe = 0;
    x = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (i == start_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_word(words[i], $urandom_range(0, max_gap));
      x = x ^ words[i];
    end
    send_word(x ^ WIDTH'(bad), $urandom_range(0, max_gap));
    tick();
    tick();
    check("end_done",    64'(done),     64'(1));
    check("end_error",   64'(err),      64'(bad));
    check("end_busy",    64'(busy),     64'(0));
    check("strobe_cnt",  64'(n_strobe), 64'(WORDS * sc()));
  endtask

  initial begin
    sel   = 1'b0;
    rst_n = 1'b0;
    start = 1'b1;
    valid = 1'b1;
    data  = $urandom;

    // Reset with start/valid asserted must leave everything quiet.
    tick();
    mon_on = 1'b1;
    tick();
    tick();
    check("rst_en",    64'(en),   64'(0));
    check("rst_d_in",  64'(d_in), 64'(0));
    check("rst_ready", 64'(rdy),  64'(0));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_done",  64'(done), 64'(0));
    check("rst_error", 64'(err),  64'(0));
    start = 1'b0;
    valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Words 1..24, trailer 0x18 good then 0x19 bad.
    for (int i = 0; i < WORDS; i++) words[i] = WIDTH'(i + 1);
    run_load(1'b0, 0, -1);
    run_load(1'b1, 0, -1);

    // Random data with random valid gaps.
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < WORDS; i++) words[i] = $urandom;
      run_load(l == 1, 7, -1);
    end

    // Reset during the strobe of word index 5.
    for (int i = 0; i < WORDS; i++) words[i] = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_word(words[i], $urandom_range(0, 3));
    for (int n = 0; n < 10 && en != 24'h000020; n++) tick();
    check("mid_en_w5", 64'(en), 64'(24'h000020));
    rst_n = 1'b0;
    tick();
    check("mid_rst_en",   64'(en),   64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    tick();
    run_load(1'b0, 2, -1);

    // Switch to the STROBE_CYCLES=3 instance; extra start pulse mid-load must be ignored.
    rst_n = 1'b0;
    tick();
    tick();
    sel = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < WORDS; i++) words[i] = $urandom;
    run_load(1'b0, 0, 3);
    for (int i = 0; i < WORDS; i++) words[i] = $urandom;
    run_load(1'b1, 5, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/configs_loader.md
# configs_loader

Write-side controller for the configuration latch array: accepts a stream of 32-bit configuration words over a valid/ready handshake and drives the latch bank's shared data bus plus one-hot enables. Each word is presented with a setup cycle, a strobe window and a hold cycle, so the level-sensitive latches capture cleanly. The loader tracks the word index, verifies a trailing XOR checksum, and reports done/error to the tile configuration master.

## Interface
- WIDTH, 32, configuration word width; equals the latch bank data width.
- WORDS, 24, number of latch enables and words per load.
- STROBE_CYCLES, 1, cycles each enable is held high (1..15).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- io_start  in  1  begin a load; sampled only in IDLE.
- io_cfg_valid  in  1  io_cfg_data holds a word.
- io_cfg_data  in  WIDTH  config word, or checksum word after the last data word.
- io_cfg_ready  out  1  loader accepts a word this cycle.
- io_d_in  out  WIDTH  data bus to the latch bank.
- io_configs_en  out  WORDS  one-hot latch enables; at most one bit high.
- io_busy  out  1  load in progress; not in IDLE.
- io_done  out  1  sticky; the last load completed.
- io_error  out  1  sticky; checksum mismatch on the last load.

## Operation
- States: IDLE, WAIT_WORD, SETUP, STROBE, HOLD, CHECK.
- IDLE: io_start=1 -> WAIT_WORD. On that transition, clear idx, running XOR, io_done and io_error.
- WAIT_WORD: io_cfg_ready=1. On valid&ready, register the word into io_d_in, XOR it into the running checksum, then go to SETUP.
- SETUP: 1 cycle. io_d_in is stable and io_configs_en=0.
- STROBE: io_configs_en = 1<<idx for STROBE_CYCLES cycles, tracked by a strobe counter. io_d_in is unchanged.
- HOLD: 1 cycle. io_configs_en=0 and io_d_in is unchanged. If idx==WORDS-1, go to CHECK; otherwise increment idx and go to WAIT_WORD.
- CHECK: io_cfg_ready=1. On valid&ready:
  - io_done=1.
  - io_error = (word != running XOR).
  - go to IDLE.
  - The checksum word is never driven onto io_d_in.
- io_d_in changes only on word acceptance in WAIT_WORD.
- io_cfg_ready is low in IDLE, SETUP, STROBE and HOLD.
- io_start outside IDLE is ignored.
- io_cfg_valid outside WAIT_WORD/CHECK has no effect. The word must be held until ready; the loader does not buffer.
- No handshake timeout: the loader waits indefinitely in WAIT_WORD or CHECK.
- A checksum mismatch does not undo latch contents. Software reloads on error.
- idx is ceil(log2(WORDS)) bits and never exceeds WORDS-1.

## Timing
- Reset (reset=0 at a rising edge) gives: state IDLE, io_configs_en=0, io_d_in=0, io_cfg_ready=0, io_busy=0, io_done=0, io_error=0, idx=0, XOR=0.
- Reset mid-load drops all enables in the same edge and returns to IDLE. Latches keep whatever they captured.
- Word accepted at edge t:
  - SETUP during cycle t+1.
  - enable high during cycles t+2 .. t+1+STROBE_CYCLES.
  - HOLD during cycle t+2+STROBE_CYCLES.
  - io_cfg_ready high again from cycle t+3+STROBE_CYCLES.
- Peak throughput is one word per STROBE_CYCLES+3 cycles. A full load takes at least WORDS*(STROBE_CYCLES+3)+1 accepted-handshake cycles after start.
- io_busy goes high the cycle after io_start is sampled, and low the cycle after the checksum is accepted. io_done and io_error change in the same edge that io_busy falls.
- io_start and the checksum acceptance in the same cycle is impossible: start is sampled only in IDLE.

## Test plan
- Reset check: hold reset=0 for 3 cycles with io_start=1 and io_cfg_valid=1 -> all outputs 0, io_cfg_ready=0, state IDLE.
- Full load, continuous valid:
  - stimulus: words 1..24, then checksum 0x00000018, STROBE_CYCLES=1.
  - required: io_configs_en walks 0x000001 through 0x800000, one bit at a time, each high for exactly 1 cycle; io_d_in equals the word throughout SETUP/STROBE/HOLD; 4 cycles per word.
  - end state: io_done=1, io_error=0.
- Bad checksum: same load with trailer 0x00000019 -> io_done=1, io_error=1, and all 24 strobes still issued.
- Handshake stalls: random valid gaps of 0–7 cycles -> no enable ever pulses without a preceding accepted word, io_d_in never changes while any enable is high, and final state matches the full load.
- Reset mid-load: assert reset=0 during STROBE of word 5 (io_configs_en=0x000020).
  - required: en=0 on the next edge, io_busy=0, io_done=0.
  - then a fresh io_start and a full load completes with io_done=1.
- STROBE_CYCLES=3 plus io_start pulsed while busy: each enable is high for exactly 3 cycles at 6 cycles per word, and the second start has no effect (idx is not reset).
